enokida_trace_buffer: RTL and testbench

- Upstream feeder for the trace-assisted direct-mapped cache. It sits between the instruction tracer and the cache's trace_in, trace_ready and lock inputs.
- Captures 160-bit trace packets into a FIFO.
- Replays each packet to the cache as registered data plus a one-cycle trace_ready strobe, paced by a minimum gap and stalled by lock.
- Counts packets dropped because the FIFO was full.

---
 rtl/enokida_trace_buffer.sv | 131 +++++++++++++
 tb/tb_enokida_trace_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/enokida_trace_buffer.sv
// Trace packet FIFO feeding the trace-assisted cache: captures tracer packets and
// replays them as registered data plus a one-cycle trace_ready strobe, paced and lockable.
module enokida_trace_buffer #(
    parameter int TRACE_WIDTH = 160,
    parameter int DEPTH       = 16,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TRACE_WIDTH-1:0]    trace_in_data,
    input  logic                      trace_in_valid,
    input  logic                      trace_capture_enable,
    input  logic                      lock,
    input  logic                      flush,
    output logic [TRACE_WIDTH-1:0]    trace_out,
    output logic                      trace_ready,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [31:0]               overflow_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    logic [TRACE_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [31:0]            ovf_q, ovf_d;
    state_t                 state_q;
    logic                   ready_q;
    logic [TRACE_WIDTH-1:0] out_q;
    logic [3:0]             gap_q;
    logic                   req, full, push, drop, pop;

    always_comb begin
        req  = trace_in_valid && trace_capture_enable && !flush;
        full = (count_q == CW'(DEPTH));
        push = req && !full;
        drop = req && full;
        pop  = (state_q == IDLE) && (count_q != '0) && !lock && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (drop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= trace_in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Read FSM; lock is only consulted in IDLE so a started strobe/gap always completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            out_q   <= '0;
            gap_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        out_q   <= mem_q[rd_ptr_q];
                        ready_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    ready_q <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q   <= GAP_LOAD;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == '0) state_q <= IDLE;
                    else             gap_q   <= gap_q - 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign trace_out      = out_q;
    assign trace_ready    = ready_q;
    assign fifo_full      = full;
    assign fifo_empty     = (count_q == '0);
    assign fifo_count     = count_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_enokida_trace_buffer.sv
// Scoreboard bench for enokida_trace_buffer: a queue-based reference model predicts
// strobes and status; a negedge monitor checks every strobe against the scoreboard.
module tb_enokida_trace_buffer;

    localparam int W     = 160;
    localparam int DEPTH = 16;
    localparam int GAP   = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  trace_in_data = '0;
    logic          trace_in_valid = 1'b0;
    logic          trace_capture_enable = 1'b0;
    logic          lock = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  trace_out;
    logic          trace_ready;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   overflow_count;

    enokida_trace_buffer #(
        .TRACE_WIDTH(W),
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trace_in_data(trace_in_data),
        .trace_in_valid(trace_in_valid),
        .trace_capture_enable(trace_capture_enable),
        .lock(lock),
        .flush(flush),
        .trace_out(trace_out),
        .trace_ready(trace_ready),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mq[$];
    int           cyc = 0;
    int           idle_at = 0;
    logic [31:0]  m_ovf = '0;
    logic [W-1:0] m_out = '0;
    logic         m_ready = 1'b0;
    int           checks = 0;
    int           failures = 0;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: strobes may only issue from IDLE, which is revisited 2+GAP edges after a pop.
    task automatic model_edge(input logic v, input logic en, input logic lk,
                              input logic fl, input logic [W-1:0] d, input logic r);
        bit full;
        if (r) begin
            mq.delete();
            idle_at = cyc + 1;
            m_ovf   = '0;
            m_out   = '0;
            m_ready = 1'b0;
        end else begin
            full    = (mq.size() == DEPTH);
            m_ready = 1'b0;
            if (fl) begin
                mq.delete();
                idle_at = cyc + 1;
            end else begin
                if (cyc >= idle_at && mq.size() > 0 && !lk) begin
                    m_out   = mq.pop_front();
                    m_ready = 1'b1;
                    idle_at = cyc + 2 + GAP;
                    sb.push_back('{data: m_out, cyc: cyc});
                end
                if (v && en) begin
                    if (!full) mq.push_back(d);
                    else if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic en, input logic lk,
                        input logic fl, input logic [W-1:0] d, input logic r);
        trace_in_valid       = v;
        trace_capture_enable = en;
        lock                 = lk;
        flush                = fl;
        trace_in_data        = d;
        rst                  = r;
        @(posedge clk);
        cyc++;
        model_edge(v, en, lk, fl, d, r);
        #1;
        chk("fifo_count", W'(fifo_count), W'(mq.size()));
        chk("fifo_full", W'(fifo_full), W'(mq.size() == DEPTH));
        chk("fifo_empty", W'(fifo_empty), W'(mq.size() == 0));
        chk("overflow_count", W'(overflow_count), W'(m_ovf));
        chk("trace_out_hold", trace_out, m_out);
        chk("trace_ready", W'(trace_ready), W'(m_ready));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic lk, input logic [W-1:0] d);
        step(1'b1, 1'b1, lk, 1'b0, d, 1'b0);
    endtask

    // Monitor: every observed strobe must match the oldest predicted one, data and cycle.
    always @(negedge clk) begin
        if (trace_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", W'(1), W'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_data", trace_out, e.data);
                chk("strobe_cycle", W'(cyc), W'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_data(), 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, rnd_data(), 1'b1);
        push(1'b0, W'(8'hA5));
        idle(4);

        for (int i = 1; i <= 4; i++) push(1'b0, W'(i));
        idle(12);

        for (int i = 0; i < 20; i++) push(1'b1, rnd_data());
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(60);

        for (int i = 0; i < 4; i++) push(1'b0, rnd_data());
        for (int i = 0; i < 10 && !m_ready; i++) idle(1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(15);

        for (int i = 0; i < 5; i++) push(1'b1, rnd_data());
        step(1'b1, 1'b1, 1'b1, 1'b1, rnd_data(), 1'b0);
        idle(8);

        for (int i = 0; i < 16; i++) push(1'b1, rnd_data());
        for (int i = 0; i < 40; i++) push(1'b0, rnd_data());
        idle(70);

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 39) == 0),
                 rnd_data(),
                 1'($urandom_range(0, 199) == 0));
        end
        idle(70);

        chk("scoreboard_drained", W'(sb.size()), W'(0));
        chk("model_drained", W'(mq.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
